rom_port_arbiter: RTL and testbench
===================================

Name: rom_port_arbiter

Overview:
- Shares one single-port instruction/data memory between two requesters: port A (processor fetch/load path) and port B (VGA sprite/background reader for the game display).
- The memory has one registered read cycle: on a clock edge it captures the read at `addr` when `wEn`=0, or writes when `wEn`=1.
- The block performs per-cycle arbitration with req/gnt handshakes, a bounded starvation guarantee for port B, and routes read data back with a valid strobe.

Parameters:
- DATA_WIDTH, 32, memory word width.
- ADDRESS_WIDTH, 12, memory address width.
- MAX_WAIT, 4, cycles port B may be denied before it is force-granted; legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- a_req  input  1  port A request; held with stable fields until a_gnt.
- a_wEn  input  1  port A write (1) / read (0).
- a_addr  input  ADDRESS_WIDTH  port A address.
- a_dataIn  input  DATA_WIDTH  port A write data.
- a_gnt  output  1  port A access issued to memory this cycle.
- a_rvalid  output  1  a_rdata valid (read response).
- a_rdata  output  DATA_WIDTH  port A read data.
- b_req, b_wEn, b_addr, b_dataIn, b_gnt, b_rvalid, b_rdata: same as port A, for port B.
- mem_wEn  output  1  to memory wEn.
- mem_addr  output  ADDRESS_WIDTH  to memory addr.
- mem_dataIn  output  DATA_WIDTH  to memory dataIn.
- mem_dataOut  input  DATA_WIDTH  from memory dataOut; valid one cycle after a read issue.

Behaviour:
- Arbitration is combinational within cycle t from a_req, b_req and the registered state: last_grant (A/B) and b_wait counter (8 bits).
- At most one of a_gnt/b_gnt is high; gnt is never high without the matching req.
- The selected port's wEn/addr/dataIn drive mem_* in the same cycle t.
- No grant: mem_wEn=0, mem_addr=a_addr, mem_dataIn=0. This is a harmless read; no rvalid follows.
- Fixed-priority mode (default), in priority order:
  - If b_req and b_wait==MAX_WAIT, grant B.
  - Else if a_req, grant A.
  - Else if b_req, grant B.
- b_wait:
  - Increments (saturating at MAX_WAIT) each cycle b_req=1 and b_gnt=0.
  - Clears on b_gnt or when b_req=0.
- Read response:
  - Registered pend_a/pend_b flags are set when a read (wEn=0) is granted.
  - In cycle t+1: x_rvalid=1 and x_rdata=mem_dataOut for the pending port.
  - x_rdata is 0 whenever x_rvalid=0.
  - Writes produce no rvalid.
- Throughput: one access per cycle. A port may be granted on back-to-back cycles; responses then stream on consecutive cycles.
- Requester rule: after a gnt, the requester may immediately present a new request (or the same one for a new access) the next cycle. A dropped req without gnt is legal and is simply not served.
- Simultaneous events: both ports request the same address with A writing and B reading. Whichever is granted first is ordered first. A B read granted after an A write returns the new data.
- last_grant updates to the granted port on every grant; it holds when idle.
- Reset (synchronous, active-high), effective in any cycle including mid-operation:
  - All gnt/rvalid are forced 0 during the reset cycle and mem_wEn=0.
  - pend_a=pend_b=0, b_wait=0, last_grant=B (A wins first arbitration after reset).
  - A read granted in the cycle before reset asserts produces no rvalid after reset.
  - All rdata outputs read 0 out of reset.

Optional Feature:
- Macro: ROM_ARB_ROUND_ROBIN_EN.
- Defined: arbitration is round-robin. With both requesting, the port opposite last_grant wins. With a single requester, it always wins. b_wait logic is not instantiated and MAX_WAIT is ignored.
- Undefined: fixed priority to A with the MAX_WAIT starvation guard as above.

Test Plan:
- Reset, then a_req=1 read addr 0x010 (memory preloaded 0x010=0xDEADBEEF) → a_gnt=1 in cycle t; a_rvalid=1, a_rdata=0xDEADBEEF in t+1; b_* all 0.
- A write 0x005←0x12345678 granted in cycle t, then B read 0x005 in t+1 → b_gnt in t+1; b_rvalid with 0x12345678 in t+2; no a_rvalid.
- Fixed priority, MAX_WAIT=4, a_req and b_req both held high for 10 cycles:
  - A is granted in cycles 0–3, B in cycle 4, A in cycles 5–8, B in cycle 9.
  - Never both gnt high.
- ROM_ARB_ROUND_ROBIN_EN defined, both requesting continuously from reset → grants alternate A,B,A,B…; rvalid alternates correspondingly one cycle later.
- B read granted in cycle t, reset asserted in t+1 → b_rvalid=0 in t+1 and t+2; after reset deasserts, a simultaneous A/B request grants A first.
- No requests for 5 cycles → mem_wEn=0, all gnt/rvalid 0, rdata 0, b_wait stays 0.

Source files
------------

// File: rtl/rom_port_arbiter_if.sv
// Requester-side and memory-side bundles for rom_port_arbiter.
// Each requester port is one rom_port_if instance; the shared memory is one rom_mem_if.
interface rom_port_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
);
  logic                     req;
  logic                     wEn;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]    dataIn;
  logic                     gnt;
  logic                     rvalid;
  logic [DATA_WIDTH-1:0]    rdata;

  // The requester holds req and its fields stable until it sees gnt.
  modport master (output req, wEn, addr, dataIn, input  gnt, rvalid, rdata);
  modport slave  (input  req, wEn, addr, dataIn, output gnt, rvalid, rdata);
endinterface

interface rom_mem_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12
);
  logic                     wEn;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]    dataIn;
  logic [DATA_WIDTH-1:0]    dataOut;

  // dataOut carries the read captured on the previous clock edge.
  modport master (output wEn, addr, dataIn, input  dataOut);
  modport slave  (input  wEn, addr, dataIn, output dataOut);
endinterface

// File: rtl/rom_port_arbiter.sv
// Two-port arbiter in front of a single-port, one-cycle-latency memory.
// Define ROM_ARB_ROUND_ROBIN_EN for round-robin; default is A-priority with a B starvation guard.
module rom_arb_resp #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue,
  input  logic [DATA_WIDTH-1:0] dataOut,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic pend;

  always_ff @(posedge clk) begin
    if (reset) pend <= 1'b0;
    else       pend <= issue;
  end

  // A read issued just before reset must not surface during the reset cycle.
  assign rvalid = pend & ~reset;
  assign rdata  = rvalid ? dataOut : '0;
endmodule

module rom_port_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int MAX_WAIT      = 4
) (
  input  logic       clk,
  input  logic       reset,
  rom_port_if.slave  a,
  rom_port_if.slave  b,
  rom_mem_if.master  mem
);
  localparam int NUM_PORTS = 2;
  localparam int PA = 0;
  localparam int PB = 1;

  logic [NUM_PORTS-1:0]                 sel;
  logic [NUM_PORTS-1:0]                 rd_issue;
  logic [NUM_PORTS-1:0]                 rvalid;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rdata;

`ifdef ROM_ARB_ROUND_ROBIN_EN
  typedef enum logic {GNT_A = 1'b0, GNT_B = 1'b1} grant_e;
  grant_e last_grant;

  always_ff @(posedge clk) begin
    if (reset)       last_grant <= GNT_B;
    else if (sel[PA]) last_grant <= GNT_A;
    else if (sel[PB]) last_grant <= GNT_B;
  end

  always_comb begin
    sel = '0;
    if (a.req && b.req) begin
      if (last_grant == GNT_A) sel[PB] = 1'b1;
      else                     sel[PA] = 1'b1;
    end else if (a.req) begin
      sel[PA] = 1'b1;
    end else if (b.req) begin
      sel[PB] = 1'b1;
    end
    if (reset) sel = '0;
  end
`else
  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);
  logic [7:0] b_wait;

  // Count consecutive denied cycles of B; a dropped request forfeits its credit.
  always_ff @(posedge clk) begin
    if (reset)                  b_wait <= '0;
    else if (b.req && !sel[PB]) b_wait <= (b_wait == WAIT_MAX) ? b_wait : b_wait + 8'd1;
    else                        b_wait <= '0;
  end

  always_comb begin
    sel = '0;
    if (b.req && b_wait == WAIT_MAX) sel[PB] = 1'b1;
    else if (a.req)                  sel[PA] = 1'b1;
    else if (b.req)                  sel[PB] = 1'b1;
    if (reset) sel = '0;
  end
`endif

  assign a.gnt = sel[PA];
  assign b.gnt = sel[PB];

  // Idle cycles present a harmless read of a.addr with no response attached.
  always_comb begin
    mem.wEn    = 1'b0;
    mem.addr   = a.addr;
    mem.dataIn = '0;
    if (sel[PB]) begin
      mem.wEn    = b.wEn;
      mem.addr   = b.addr;
      mem.dataIn = b.dataIn;
    end else if (sel[PA]) begin
      mem.wEn    = a.wEn;
      mem.addr   = a.addr;
      mem.dataIn = a.dataIn;
    end
  end

  assign rd_issue[PA] = sel[PA] & ~a.wEn;
  assign rd_issue[PB] = sel[PB] & ~b.wEn;

  generate
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_resp
      rom_arb_resp #(.DATA_WIDTH(DATA_WIDTH)) u_resp (
        .clk     (clk),
        .reset   (reset),
        .issue   (rd_issue[g]),
        .dataOut (mem.dataOut),
        .rvalid  (rvalid[g]),
        .rdata   (rdata[g])
      );
    end
  endgenerate

  assign a.rvalid = rvalid[PA];
  assign a.rdata  = rdata[PA];
  assign b.rvalid = rvalid[PB];
  assign b.rdata  = rdata[PB];
endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed self-checking bench for rom_port_arbiter with a behavioural memory.
// Expectations follow ROM_ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_rom_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  rom_port_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) pa ();
  rom_port_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) pb ();
  rom_mem_if  #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) mi ();

  rom_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (pa),
    .b     (pb),
    .mem   (mi)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem_arr [0:(1<<AW)-1];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) mem_arr[pl_addr] <= pl_data;
    else if (mi.wEn) mem_arr[mi.addr] <= mi.dataIn;
    mi.dataOut <= mem_arr[mi.addr];
  end

  task automatic set_a(input logic req, input logic wen, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    pa.req = req; pa.wEn = wen; pa.addr = ad; pa.dataIn = d;
  endtask

  task automatic set_b(input logic req, input logic wen, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    pb.req = req; pb.wEn = wen; pb.addr = ad; pb.dataIn = d;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; pl_en = 1'b1; pl_addr = 12'h010; pl_data = 32'hDEADBEEF;
    set_a(1'b1, 1'b0, 12'h010, '0);
    set_b(1'b1, 1'b0, 12'h005, '0);
    next_cycle();
    pl_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({pa.gnt, pb.gnt, mi.wEn, pa.rvalid, pb.rvalid} !== 5'b0) begin
      n_err++; $display("FAIL reset_outputs: gnt/wEn/rvalid got %b want 00000",
                        {pa.gnt, pb.gnt, mi.wEn, pa.rvalid, pb.rvalid});
    end
    next_cycle();
    reset = 1'b0;
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_cmp++;
    if ({pa.rvalid, pb.rvalid, pa.rdata, pb.rdata} !== '0) begin
      n_err++; $display("FAIL reset_rdata: rvalid %b%b rdata %h %h want zeros",
                        pa.rvalid, pb.rvalid, pa.rdata, pb.rdata);
    end
  endtask

  task automatic test_read_a();
    next_cycle();
    set_a(1'b1, 1'b0, 12'h010, '0);
    @(negedge clk);
    n_cmp++;
    if ({pa.gnt, pb.gnt, mi.wEn, mi.addr} !== {3'b100, 12'h010}) begin
      n_err++; $display("FAIL read_a_issue: gnt %b%b wEn %b addr %h want 10 0 010",
                        pa.gnt, pb.gnt, mi.wEn, mi.addr);
    end
    next_cycle();
    set_a(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_cmp++;
    if ({pa.rvalid, pa.rdata} !== {1'b1, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL read_a_resp: rvalid %b rdata %h want 1 deadbeef", pa.rvalid, pa.rdata);
    end
    n_cmp++;
    if ({pb.gnt, pb.rvalid, pb.rdata} !== '0) begin
      n_err++; $display("FAIL read_a_b_quiet: b gnt %b rvalid %b rdata %h want zeros",
                        pb.gnt, pb.rvalid, pb.rdata);
    end
  endtask

  task automatic test_write_then_read();
    next_cycle();
    set_a(1'b1, 1'b1, 12'h005, 32'h12345678);
    @(negedge clk);
    n_cmp++;
    if ({pa.gnt, mi.wEn, mi.addr, mi.dataIn} !== {2'b11, 12'h005, 32'h12345678}) begin
      n_err++; $display("FAIL write_issue: gnt %b wEn %b addr %h din %h want 1 1 005 12345678",
                        pa.gnt, mi.wEn, mi.addr, mi.dataIn);
    end
    next_cycle();
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b1, 1'b0, 12'h005, '0);
    @(negedge clk);
    n_cmp++;
    if ({pa.gnt, pb.gnt, pa.rvalid, mi.wEn} !== 4'b0100) begin
      n_err++; $display("FAIL raw_b_issue: gnt %b%b a_rvalid %b wEn %b want 01 0 0",
                        pa.gnt, pb.gnt, pa.rvalid, mi.wEn);
    end
    next_cycle();
    set_b(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_cmp++;
    if ({pb.rvalid, pb.rdata, pa.rvalid} !== {1'b1, 32'h12345678, 1'b0}) begin
      n_err++; $display("FAIL raw_b_resp: b_rvalid %b rdata %h a_rvalid %b want 1 12345678 0",
                        pb.rvalid, pb.rdata, pa.rvalid);
    end
  endtask

  // Both ports request for 10 cycles; B is granted on cycles 4 and 9 (fixed)
  // or on every odd cycle (round-robin, B was the last winner going in).
  task automatic test_contention();
    logic prev_b, exp_b;
    prev_b = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      next_cycle();
      if (k < 10) begin
        set_a(1'b1, 1'b0, 12'h010, '0);
        set_b(1'b1, 1'b0, 12'h005, '0);
      end else begin
        set_a(1'b0, 1'b0, '0, '0);
        set_b(1'b0, 1'b0, '0, '0);
      end
      @(negedge clk);
`ifdef ROM_ARB_ROUND_ROBIN_EN
      exp_b = (k % 2 == 1);
`else
      exp_b = (k == 4 || k == 9);
`endif
      if (k < 10) begin
        n_cmp++;
        if ({pa.gnt, pb.gnt} !== {~exp_b, exp_b}) begin
          n_err++; $display("FAIL contention_gnt[%0d]: gnt %b%b want %b%b", k, pa.gnt, pb.gnt, ~exp_b, exp_b);
        end
      end
      if (k > 0) begin
        n_cmp++;
        if ({pa.rvalid, pb.rvalid, pa.rdata, pb.rdata} !==
            {~prev_b, prev_b, prev_b ? 32'h0 : 32'hDEADBEEF, prev_b ? 32'h12345678 : 32'h0}) begin
          n_err++; $display("FAIL contention_resp[%0d]: rvalid %b%b rdata %h %h prev_b %b",
                            k, pa.rvalid, pb.rvalid, pa.rdata, pb.rdata, prev_b);
        end
      end
      prev_b = exp_b;
    end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    set_b(1'b1, 1'b0, 12'h005, '0);
    @(negedge clk);
    n_cmp++;
    if (pb.gnt !== 1'b1) begin
      n_err++; $display("FAIL midrst_b_issue: b_gnt %b want 1", pb.gnt);
    end
    next_cycle();
    reset = 1'b1;
    set_b(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_cmp++;
    if ({pb.rvalid, pb.rdata, pa.gnt, pb.gnt, mi.wEn} !== '0) begin
      n_err++; $display("FAIL midrst_in_reset: b_rvalid %b rdata %h gnt %b%b wEn %b want zeros",
                        pb.rvalid, pb.rdata, pa.gnt, pb.gnt, mi.wEn);
    end
    next_cycle();
    reset = 1'b0;
    set_a(1'b1, 1'b0, 12'h010, '0);
    set_b(1'b1, 1'b0, 12'h005, '0);
    @(negedge clk);
    n_cmp++;
    if ({pb.rvalid, pa.gnt, pb.gnt} !== 3'b010) begin
      n_err++; $display("FAIL midrst_after: b_rvalid %b gnt %b%b want 0 10", pb.rvalid, pa.gnt, pb.gnt);
    end
    next_cycle();
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    n_cmp++;
    if ({pa.rvalid, pa.rdata, pb.rvalid} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
      n_err++; $display("FAIL midrst_a_resp: a_rvalid %b rdata %h b_rvalid %b want 1 deadbeef 0",
                        pa.rvalid, pa.rdata, pb.rvalid);
    end
  endtask

  task automatic test_idle();
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      @(negedge clk);
      n_cmp++;
      if ({mi.wEn, mi.dataIn, pa.gnt, pb.gnt, pa.rvalid, pb.rvalid, pa.rdata, pb.rdata} !== '0) begin
        n_err++; $display("FAIL idle[%0d]: wEn %b din %h gnt %b%b rvalid %b%b rdata %h %h want zeros",
                          k, mi.wEn, mi.dataIn, pa.gnt, pb.gnt, pa.rvalid, pb.rvalid, pa.rdata, pb.rdata);
      end
`ifndef ROM_ARB_ROUND_ROBIN_EN
      n_cmp++;
      if (dut.b_wait !== 8'd0) begin
        n_err++; $display("FAIL idle_bwait[%0d]: b_wait %0d want 0", k, dut.b_wait);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_read_a();
    test_write_then_read();
    test_contention();
    test_reset_mid();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
